// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding, reset PC and
// instruction width, used by the fetch stage and the control unit.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10,
    ST_KILL = 2'b11
  } fetch_state_e;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the fetch stage: reset, redirect,
// J/JAL pre-decode (only when JUMP_PREDECODE_EN is defined), pc+4, or hold.
module fetch_next_pc
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                i_reset,
  input  logic                i_redirect_valid,
  input  logic [ADDR_W-1:0]   i_redirect_pc,
  input  logic                i_capture,
  input  logic [ADDR_W-1:0]   i_pc,
  input  logic [INSTR_W-1:0]  i_rsp_data,
  output logic [ADDR_W-1:0]   o_next_pc
);

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_redirect_aligned;
  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_unused;

  assign w_pc_plus4         = i_pc + ADDR_W'(4);
  assign w_redirect_aligned = {i_redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef JUMP_PREDECODE_EN
  // Jump target keeps the upper bits of the delay-slot PC.
  assign w_seq_pc = is_jump_op(i_rsp_data[31:26]) ?
                    {w_pc_plus4[ADDR_W-1:28], i_rsp_data[25:0], 2'b00} : w_pc_plus4;
  assign w_unused = ^i_redirect_pc[1:0];
`else
  assign w_seq_pc = w_pc_plus4;
  assign w_unused = ^{i_redirect_pc[1:0], i_rsp_data};
`endif

  // Priority: reset, then redirect, then sequential advance on capture.
  always_comb begin
    w_next_pc = i_pc;
    if (i_reset) begin
      w_next_pc = RESET_PC;
    end else if (i_redirect_valid) begin
      w_next_pc = w_redirect_aligned;
    end else if (i_capture) begin
      w_next_pc = w_seq_pc;
    end else begin
      w_next_pc = i_pc;
    end
  end

  assign o_next_pc = w_next_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one-outstanding-request instruction fetch feeding decode.
// Optional J/JAL pre-decode is enabled by defining JUMP_PREDECODE_EN.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [5:0]          opcode,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic               w_capture;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               r_instr_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;

  fetch_next_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_next_pc (
    .i_reset          (reset),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_capture        (w_capture),
    .i_pc             (r_pc),
    .i_rsp_data       (imem_rsp_data),
    .o_next_pc        (w_pc_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a redirect with a request in flight parks in KILL to drop it.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (imem_req_ready) begin
          w_state_nxt = redirect_valid ? ST_KILL : ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = imem_rsp_valid ? ST_REQ : ST_KILL;
        end else if (imem_rsp_valid) begin
          w_state_nxt = ST_HOLD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || instr_ready) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_KILL: begin
        if (imem_rsp_valid) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_KILL;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  // PC and the instruction holding register.
  always_ff @(posedge clk) begin
    r_pc <= w_pc_nxt;
    if (reset) begin
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else begin
      if (w_capture) begin
        r_instr    <= imem_rsp_data;
        r_instr_pc <= r_pc;
      end
      if (redirect_valid) begin
        r_instr_valid <= 1'b0;
      end else if (w_capture) begin
        r_instr_valid <= 1'b1;
      end else if ((r_state == ST_HOLD) && instr_ready) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign imem_req_valid = (r_state == ST_REQ) && !reset;
  assign imem_addr      = r_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign opcode         = r_instr[31:26];

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the general control unit.
- Holds the PC and issues one-outstanding-request fetches to instruction memory over a valid/ready handshake.
- Presents the fetched word, its PC and its opcode field (Instruction[31:26]) to decode/control.
- Accepts branch redirects from the datapath and optionally pre-decodes J/JAL itself.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  ADDR_W  fetch address (word aligned, [1:0]=0).
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  32  fetched instruction word.
- instr_valid  output  1  instruction available to decode.
- instr_ready  input  1  decode consumes instruction (low = stall).
- instr  output  32  held instruction word.
- instr_pc  output  ADDR_W  PC of held instruction.
- opcode  output  6  instr[31:26], feeds control unit Instruction input.
- redirect_valid  input  1  taken branch/jump from datapath.
- redirect_pc  input  ADDR_W  redirect target.

Behaviour:
- Reset (synchronous): pc=RESET_PC, state=REQ, instr_valid=0, instr=0, instr_pc=0, opcode=0, imem_req_valid=0 on the reset cycle; imem_addr=pc.
- FSM states:
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready -> WAIT.
  - WAIT: on imem_rsp_valid, latch instr=imem_rsp_data and instr_pc=pc, pc<=pc+4, instr_valid<=1 -> HOLD.
  - HOLD: instr_valid=1. On instr_ready -> REQ (same cycle instr_valid<=0). Best-case throughput is one instruction per 3 cycles; minimum latency is request accept to instr_valid = 1 cycle after rsp_valid.
  - KILL: waiting for a dropped response; on imem_rsp_valid discard data -> REQ.
- Redirect (any state): pc<=redirect_pc[ADDR_W-1:2],2'b00 and instr_valid<=0. Next state by current state:
  - REQ without ready: stays REQ with the new address next cycle.
  - REQ with ready same cycle: -> KILL.
  - WAIT without rsp_valid: -> KILL.
  - WAIT with rsp_valid same cycle: response dropped -> REQ.
  - HOLD: held instruction squashed -> REQ.
- Redirect and instr_ready in the same cycle in HOLD: the held instruction counts as consumed; the redirect still wins for the PC.
- imem_req_valid must stay asserted with a stable imem_addr until ready, unless a redirect occurs.
- imem_rsp_valid outside WAIT/KILL is ignored.
- PC wrap-around: pc+4 wraps modulo 2^ADDR_W with no flag.
- Reset mid-operation overrides everything, including a redirect the same cycle. The memory is reset by the same reset, so no stale response arrives.
- opcode is always instr[31:26]; it is meaningful only when instr_valid=1.

Optional Feature:
- Macro: JUMP_PREDECODE_EN.
- Defined: on capture in WAIT, if imem_rsp_data[31:26] is 6'b000010 (J) or 6'b000011 (JAL), the next pc is {pc_plus4[ADDR_W-1:28], imem_rsp_data[25:0], 2'b00} instead of pc+4. The instruction is still delivered to decode. An external redirect in the same cycle has priority.
- Not defined: pc+4 always; jumps arrive only via redirect_valid.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (RTYPE, LW, SW, BEQ, J, JAL, ...), shared with the control unit;
  - fetch state encoding (REQ, WAIT, HOLD, KILL);
  - RESET_PC default;
  - INSTR_W=32.
- One natural sub-module: fetch_next_pc, combinational next-PC selection (reset / redirect / jump predecode / pc+4 / hold) feeding the PC register in instruction_fetch.

Test Plan:
- Reset then memory always ready, rsp 1 cycle later, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8. Words 0x8C010004 (LW) and 0x00221820 (RTYPE) appear with opcode 6'b100011 then 6'b000000.
- instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc and instr_valid stable; no new imem_req_valid until ready returns.
- Redirect to 0x100 in WAIT before the response -> state KILL; the response data 0xDEADBEEF is never presented; next request addr=0x100.
- Redirect to 0x203 (misaligned) in HOLD -> instr_valid drops next cycle; next imem_addr=0x200.
- pc=0xFFFFFFFC fetch completes -> next imem_addr=0x00000000.
- With JUMP_PREDECODE_EN, response 0x08000040 (J) at pc 0x10 -> J delivered; next imem_addr=0x00000100. Without the macro, next imem_addr=0x14.
